// File: rtl/mdio_mgmt_master_if.sv
// rtl/mdio_mgmt_master_if.sv - request/response bus between control logic and the MDIO master
// Purpose: groups the per-frame request fields and the status/result signals.
// Signals:
//   phy_addr  [4:0]  PHY address for the frame
//   reg_addr  [4:0]  register address for the frame
//   data_in   [15:0] write data
//   start            one-cycle request pulse
//   write_en         1=write frame, 0=read frame
//   busy             frame in progress
//   data_out  [15:0] last read data
//   done             one-cycle end-of-frame pulse
// Modports: master = requester (control logic), slave = mdio_mgmt_master.
interface mdio_mgmt_master_if;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic [15:0] data_in;
  logic        start;
  logic        write_en;
  logic        busy;
  logic [15:0] data_out;
  logic        done;

  modport master (
    output phy_addr, reg_addr, data_in, start, write_en,
    input  busy, data_out, done
  );

  modport slave (
    input  phy_addr, reg_addr, data_in, start, write_en,
    output busy, data_out, done
  );
endinterface

// File: rtl/mdio_mgmt_master.sv
// rtl/mdio_mgmt_master.sv - Clause 22 MDIO management master, one frame per start pulse
// Purpose: serialises a read or write management frame onto a split t/o/i MDIO pad,
//          one bit per i_clk (MDC-rate) cycle, and captures read data.
// Ports:
//   i_clk         MDC-rate clock, all logic on posedge
//   i_rst         synchronous active-high reset (aborts any frame)
//   io_ctrl       request/status bus (slave modport)
//   o_mdio_gem_t  tristate enable: 1=released, 0=driven
//   o_mdio_gem_o  MDIO output bit
//   i_mdio_gem_i  MDIO input bit from pad
module mdio_mgmt_master #(
  parameter int PREAMBLE_LEN = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mdio_mgmt_master_if.slave   io_ctrl,
  output logic                o_mdio_gem_t,
  output logic                o_mdio_gem_o,
  input  logic                i_mdio_gem_i
);

  // Frame bit indices; PREAMBLE_LEN+32 must fit the 7-bit counter.
  localparam logic [6:0] C_ST  = 7'(PREAMBLE_LEN);
  localparam logic [6:0] C_OP  = C_ST + 7'd2;
  localparam logic [6:0] C_PHY = C_ST + 7'd4;
  localparam logic [6:0] C_REG = C_ST + 7'd9;
  localparam logic [6:0] C_TA  = C_ST + 7'd14;
  localparam logic [6:0] C_DAT = C_ST + 7'd16;
  localparam logic [6:0] C_END = C_ST + 7'd32;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
  } state_t;

  state_t      r_state, w_state;
  logic [6:0]  r_cnt, w_cnt;         // index of the frame bit presented at the next edge
  logic        r_wr, w_wr;
  logic [9:0]  r_addr, w_addr;       // {phy, reg}, shifted out MSB first
  logic [15:0] r_shift, w_shift;     // write data out / read data in
  logic        r_t, w_t;
  logic        r_o, w_o;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic [15:0] r_data_out, w_data_out;
  logic        w_accept;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_shift    <= '0;
      r_t        <= 1'b1;
      r_o        <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_wr       <= w_wr;
      r_addr     <= w_addr;
      r_shift    <= w_shift;
      r_t        <= w_t;
      r_o        <= w_o;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_data_out <= w_data_out;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt + 7'd1;
    w_wr       = r_wr;
    w_addr     = r_addr;
    w_shift    = r_shift;
    w_t        = 1'b0;
    w_o        = 1'b1;
    w_busy     = 1'b1;
    w_done     = 1'b0;
    w_data_out = r_data_out;
    w_accept   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_t      = 1'b1;
        w_busy   = 1'b0;
        w_cnt    = r_cnt;
        w_accept = io_ctrl.start;
      end
      S_PRE: begin
        if (r_cnt == C_ST - 7'd1) w_state = S_ST;
      end
      S_ST: begin
        w_o = (r_cnt != C_ST);
        if (r_cnt == C_ST + 7'd1) w_state = S_OP;
      end
      S_OP: begin
        w_o = r_wr ? (r_cnt == C_OP + 7'd1) : (r_cnt == C_OP);
        if (r_cnt == C_OP + 7'd1) w_state = S_PHYAD;
      end
      S_PHYAD: begin
        w_o    = r_addr[9];
        w_addr = {r_addr[8:0], 1'b0};
        if (r_cnt == C_PHY + 7'd4) w_state = S_REGAD;
      end
      S_REGAD: begin
        w_o    = r_addr[9];
        w_addr = {r_addr[8:0], 1'b0};
        if (r_cnt == C_REG + 7'd4) w_state = S_TA;
      end
      S_TA: begin
        // Read releases the line for both TA bits so the PHY can drive its 0.
        w_t = ~r_wr;
        w_o = r_wr ? (r_cnt == C_TA) : 1'b1;
        if (r_cnt == C_TA + 7'd1) w_state = S_DATA;
      end
      S_DATA: begin
        if (r_cnt == C_END) begin
          // Completion edge: last read bit is sampled here, and a new start may be
          // taken in the same edge so frames can run back-to-back.
          w_t      = 1'b1;
          w_busy   = 1'b0;
          w_done   = 1'b1;
          w_cnt    = r_cnt;
          w_state  = S_IDLE;
          w_accept = io_ctrl.start;
          if (!r_wr) w_data_out = {r_shift[14:0], i_mdio_gem_i};
        end else if (r_wr) begin
          w_o     = r_shift[15];
          w_shift = {r_shift[14:0], 1'b0};
        end else begin
          w_t = 1'b1;
          // Input is only looked at on edges that end a DATA bit.
          if (r_cnt != C_DAT) w_shift = {r_shift[14:0], i_mdio_gem_i};
        end
      end
      default: w_state = S_IDLE;
    endcase

    if (w_accept) begin
      w_state = S_PRE;
      w_cnt   = '0;
      w_wr    = io_ctrl.write_en;
      w_addr  = {io_ctrl.phy_addr, io_ctrl.reg_addr};
      w_shift = io_ctrl.data_in;
    end
  end

  assign o_mdio_gem_t     = r_t;
  assign o_mdio_gem_o     = r_o;
  assign io_ctrl.busy     = r_busy;
  assign io_ctrl.done     = r_done;
  assign io_ctrl.data_out = r_data_out;

endmodule

// File: tb/tb_mdio_mgmt_master.sv
// tb/tb_mdio_mgmt_master.sv - directed self-checking bench for mdio_mgmt_master
module tb_mdio_mgmt_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mdio_t;
  logic mdio_o;
  logic mdio_i = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_dout = 16'h0000;

  logic        nx_wr;
  logic [4:0]  nx_phy;
  logic [4:0]  nx_reg;
  logic [15:0] nx_data;

  mdio_mgmt_master_if bus ();

  mdio_mgmt_master #(.PREAMBLE_LEN(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .io_ctrl      (bus),
    .o_mdio_gem_t (mdio_t),
    .o_mdio_gem_o (mdio_o),
    .i_mdio_gem_i (mdio_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_o_vec(input logic wr, input logic [4:0] phy,
                                            input logic [4:0] rg, input logic [15:0] d);
    logic [1:0]  op;
    logic [1:0]  ta;
    logic [15:0] dd;
    op = wr ? 2'b01 : 2'b10;
    ta = wr ? 2'b10 : 2'b11;
    dd = wr ? d : 16'hFFFF;
    return {32'hFFFF_FFFF, 2'b01, op, phy, rg, ta, dd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                         input logic [15:0] d);
    bus.start    = 1'b1;
    bus.write_en = wr;
    bus.phy_addr = phy;
    bus.reg_addr = rg;
    bus.data_in  = d;
  endtask

  task automatic run_frame(input string name, input logic wr, input logic [4:0] phy,
                           input logic [4:0] rg, input logic [15:0] wdata,
                           input logic [15:0] rdata, input int do_start,
                           input int inject_at, input int abort_at, input int chain);
    logic [63:0] cap_o;
    logic [63:0] cap_t;
    logic [63:0] exp_t;
    int busy_cnt;
    int done_cnt;
    if (do_start != 0) begin
      set_req(wr, phy, rg, wdata);
      tick();
      bus.start = 1'b0;
    end
    check($sformatf("%s.busy_e0", name), 64'(bus.busy), 64'd0);
    cap_o = '0;
    cap_t = '0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      tick();
      cap_o[6'(63 - k)] = mdio_o;
      cap_t[6'(63 - k)] = mdio_t;
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
      mdio_i = (!wr && k >= 48) ? rdata[4'(63 - k)] : 1'b1;
      if (k == inject_at) set_req(~wr, 5'd0, 5'd31, ~wdata);
      if (k == inject_at + 1) bus.start = 1'b0;
      if (chain != 0 && k == 63) set_req(nx_wr, nx_phy, nx_reg, nx_data);
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdio_i = 1'b1;
        exp_dout = 16'h0000;
        check($sformatf("%s.rst_t", name), 64'(mdio_t), 64'd1);
        check($sformatf("%s.rst_o", name), 64'(mdio_o), 64'd1);
        check($sformatf("%s.rst_busy", name), 64'(bus.busy), 64'd0);
        check($sformatf("%s.rst_done", name), 64'(bus.done), 64'd0);
        check($sformatf("%s.rst_dout", name), 64'(bus.data_out), 64'(exp_dout));
        return;
      end
    end
    tick();
    bus.start = 1'b0;
    mdio_i = 1'b1;
    exp_t = wr ? 64'd0 : 64'h0000_0000_0003_FFFF;
    check($sformatf("%s.o_bits", name), cap_o, exp_o_vec(wr, phy, rg, wdata));
    check($sformatf("%s.t_bits", name), cap_t, exp_t);
    check($sformatf("%s.busy_cycles", name), 64'(busy_cnt), 64'd64);
    check($sformatf("%s.done_in_frame", name), 64'(done_cnt), 64'd0);
    check($sformatf("%s.done_end", name), 64'(bus.done), 64'd1);
    check($sformatf("%s.busy_end", name), 64'(bus.busy), 64'd0);
    check($sformatf("%s.t_end", name), 64'(mdio_t), 64'd1);
    check($sformatf("%s.o_end", name), 64'(mdio_o), 64'd1);
    if (!wr) exp_dout = rdata;
    check($sformatf("%s.dout", name), 64'(bus.data_out), 64'(exp_dout));
    if (chain == 0) begin
      tick();
      check($sformatf("%s.done_after", name), 64'(bus.done), 64'd0);
      check($sformatf("%s.busy_after", name), 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.write_en = 1'b0;
    bus.phy_addr = 5'd0;
    bus.reg_addr = 5'd0;
    bus.data_in  = 16'h0000;
    nx_wr   = 1'b0;
    nx_phy  = 5'd0;
    nx_reg  = 5'd0;
    nx_data = 16'h0000;
    rst = 1'b1;
    tick();
    tick();
    check("reset.t", 64'(mdio_t), 64'd1);
    check("reset.o", 64'(mdio_o), 64'd1);
    check("reset.busy", 64'(bus.busy), 64'd0);
    check("reset.done", 64'(bus.done), 64'd0);
    check("reset.dout", 64'(bus.data_out), 64'd0);
    rst = 1'b0;
    tick();

    run_frame("wr_5_10", 1'b1, 5'd5, 5'd10, 16'hAAAA, 16'h0000, 1, -1, -1, 0);
    run_frame("rd_1_2", 1'b0, 5'd1, 5'd2, 16'h0000, 16'h1234, 1, -1, -1, 0);
    run_frame("wr_inject", 1'b1, 5'd3, 5'd7, 16'h5A5A, 16'h0000, 1, 20, -1, 0);
    run_frame("abort", 1'b1, 5'd9, 5'd4, 16'h1111, 16'h0000, 1, -1, 40, 0);
    tick();
    run_frame("after_abort", 1'b1, 5'd9, 5'd4, 16'h1111, 16'h0000, 1, -1, -1, 0);

    nx_wr   = 1'b0;
    nx_phy  = 5'd4;
    nx_reg  = 5'd5;
    nx_data = 16'h0000;
    run_frame("b2b_wr", 1'b1, 5'd2, 5'd3, 16'hC3C3, 16'h0000, 1, -1, -1, 1);
    run_frame("b2b_rd", 1'b0, 5'd4, 5'd5, 16'h0000, 16'hBEEF, 0, -1, -1, 0);

    run_frame("bnd_rd_ffff", 1'b0, 5'd31, 5'd0, 16'h0000, 16'hFFFF, 1, -1, -1, 0);
    run_frame("bnd_wr_ffff", 1'b1, 5'd31, 5'd0, 16'hFFFF, 16'h0000, 1, -1, -1, 0);
    run_frame("bnd_rd_0000", 1'b0, 5'd31, 5'd0, 16'h0000, 16'h0000, 1, -1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
